// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32 subset decode stage: register file, control/immediate decode, ID/EX register.
// Register file and ID/EX register share the asynchronous active-high reset.
module decode_stage #(
  parameter int WB_BYPASS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction_decode,
  input  logic [31:0] pc_decode,
  input  logic [31:0] next_pc_decode,
  input  logic        reg_write_writeback,
  input  logic [4:0]  rd_writeback,
  input  logic [31:0] result_writeback,
  input  logic        stall_decode,
  input  logic        flush_execute,
  output logic [4:0]  rs1_decode,
  output logic [4:0]  rs2_decode,
  output logic        reg_write_execute,
  output logic [1:0]  result_src_execute,
  output logic        mem_write_execute,
  output logic        jump_execute,
  output logic        branch_execute,
  output logic        alu_src_execute,
  output logic [2:0]  alu_control_execute,
  output logic [31:0] rd1_execute,
  output logic [31:0] rd2_execute,
  output logic [31:0] imm_ext_execute,
  output logic [4:0]  rd_execute,
  output logic [4:0]  rs1_execute,
  output logic [4:0]  rs2_execute,
  output logic [31:0] pc_execute,
  output logic [31:0] next_pc_execute
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    logic [2:0]  alu_control;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm_ext;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] pc;
    logic [31:0] next_pc;
  } idex_t;

  logic [31:0] rf_q [32];
  idex_t       idex_q, idex_d, dec;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_b5;
  logic        wb_active;

  assign opcode     = instruction_decode[6:0];
  assign funct3     = instruction_decode[14:12];
  assign funct7_b5  = instruction_decode[30];
  assign rs1_decode = instruction_decode[19:15];
  assign rs2_decode = instruction_decode[24:20];
  assign wb_active  = reg_write_writeback && (rd_writeback != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else if (wb_active) begin
      rf_q[rd_writeback] <= result_writeback;
    end
  end

  // x0 is hard-wired; the bypass only applies to a live, nonzero write-back.
  function automatic logic [31:0] rf_read(input logic [4:0] addr);
    if (addr == 5'd0)
      return 32'd0;
    else if ((WB_BYPASS != 0) && wb_active && (rd_writeback == addr))
      return result_writeback;
    else
      return rf_q[addr];
  endfunction

  logic [31:0] imm_i, imm_s, imm_b, imm_j;
  assign imm_i = {{20{instruction_decode[31]}}, instruction_decode[31:20]};
  assign imm_s = {{20{instruction_decode[31]}}, instruction_decode[31:25], instruction_decode[11:7]};
  assign imm_b = {{20{instruction_decode[31]}}, instruction_decode[7], instruction_decode[30:25],
                  instruction_decode[11:8], 1'b0};
  assign imm_j = {{12{instruction_decode[31]}}, instruction_decode[19:12], instruction_decode[20],
                  instruction_decode[30:21], 1'b0};

  always_comb begin
    dec         = '0;
    dec.rd1     = rf_read(rs1_decode);
    dec.rd2     = rf_read(rs2_decode);
    dec.rd      = instruction_decode[11:7];
    dec.rs1     = rs1_decode;
    dec.rs2     = rs2_decode;
    dec.pc      = pc_decode;
    dec.next_pc = next_pc_decode;
    case (opcode)
      OP_LW: begin
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b01;
        dec.alu_src    = 1'b1;
        dec.imm_ext    = imm_i;
      end
      OP_SW: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_ext   = imm_s;
      end
      OP_BEQ: begin
        dec.branch      = 1'b1;
        dec.alu_control = 3'b001;
        dec.imm_ext     = imm_b;
      end
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b10;
        dec.jump       = 1'b1;
        dec.imm_ext    = imm_j;
      end
      OP_R, OP_I: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = (opcode == OP_I);
        dec.imm_ext   = (opcode == OP_I) ? imm_i : 32'd0;
        case (funct3)
          3'b000:  dec.alu_control = ((opcode == OP_R) && funct7_b5) ? 3'b001 : 3'b000;
          3'b111:  dec.alu_control = 3'b010;
          3'b110:  dec.alu_control = 3'b011;
          3'b010:  dec.alu_control = 3'b101;
          default: begin
            // Unsupported ALU op degrades to a NOP.
            dec.reg_write = 1'b0;
            dec.alu_src   = 1'b0;
            dec.imm_ext   = 32'd0;
          end
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    idex_d = idex_q;
    if (flush_execute)
      idex_d = '0;
    else if (!stall_decode)
      idex_d = dec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idex_q <= '0;
    else     idex_q <= idex_d;
  end

  assign reg_write_execute   = idex_q.reg_write;
  assign result_src_execute  = idex_q.result_src;
  assign mem_write_execute   = idex_q.mem_write;
  assign jump_execute        = idex_q.jump;
  assign branch_execute      = idex_q.branch;
  assign alu_src_execute     = idex_q.alu_src;
  assign alu_control_execute = idex_q.alu_control;
  assign rd1_execute         = idex_q.rd1;
  assign rd2_execute         = idex_q.rd2;
  assign imm_ext_execute     = idex_q.imm_ext;
  assign rd_execute          = idex_q.rd;
  assign rs1_execute         = idex_q.rs1;
  assign rs2_execute         = idex_q.rs2;
  assign pc_execute          = idex_q.pc;
  assign next_pc_execute     = idex_q.next_pc;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter WB_BYPASS, default 1, meaning a write-back to a register being read in the same cycle returns the new value.
REQ-002 SHALL have ports clk in 1: clock, rising edge; rst in 1: reset, asynchronous, active-high.
REQ-003 SHALL have instruction_decode in 32: instruction from fetch; pc_decode in 32: its PC; next_pc_decode in 32: PC+4.
REQ-004 SHALL have reg_write_writeback in 1, rd_writeback in 5 and result_writeback in 32: register-file write port.
REQ-005 SHALL have stall_decode in 1 (hold ID/EX register) and flush_execute in 1 (load bubble into ID/EX).
REQ-006 SHALL have rs1_decode out 5 and rs2_decode out 5: combinational source fields for the hazard unit.
REQ-007 SHALL have control outputs reg_write_execute 1, result_src_execute 2, mem_write_execute 1, jump_execute 1, branch_execute 1, alu_src_execute 1, alu_control_execute 3.
REQ-008 SHALL have data outputs rd1_execute 32, rd2_execute 32, imm_ext_execute 32, rd_execute 5, rs1_execute 5, rs2_execute 5, pc_execute 32, next_pc_execute 32.

Function
REQ-009 SHALL hold a 32x32 register file; x0 reads 0 always; writes to x0 are ignored.
REQ-010 SHALL write result_writeback to the register addressed by rd_writeback on rising clk when reg_write_writeback=1 and rd_writeback!=0.
REQ-011 SHALL, with WB_BYPASS=1, return result_writeback on a read port whose address equals a nonzero rd_writeback while reg_write_writeback=1; with WB_BYPASS=0, SHALL return the old value.
REQ-012 SHALL decode opcodes: 0000011 lw, 0100011 sw, 0110011 R-type, 0010011 I-ALU, 1100011 beq, 1101111 jal.
REQ-013 SHALL generate these controls (reg_write, result_src, mem_write, alu_src, branch, jump): lw 1,01,0,1,0,0; sw 0,00,1,1,0,0; R 1,00,0,0,0,0; I-ALU 1,00,0,1,0,0; beq 0,00,0,0,1,0; jal 1,10,0,0,0,1.
REQ-014 SHALL set alu_control: 000 add for lw, sw and jal; 001 sub for beq.
REQ-015 SHALL set alu_control for R and I-ALU from funct3: 000 add, except R-type with funct7[5]=1 gives sub 001; 111 gives and 010; 110 gives or 011; 010 gives slt 101.
REQ-016 SHALL decode any other opcode, or any unlisted funct3, as NOP: all controls 0 and alu_control 000.
REQ-017 SHALL sign-extend immediates from bit 31: I {inst[31:20]}; S {inst[31:25],inst[11:7]}; B {inst[31],inst[7],inst[30:25],inst[11:8],0}; J {inst[31],inst[19:12],inst[20],inst[30:21],0}.
REQ-018 SHALL set imm_ext to 0 for R-type and NOP.
REQ-019 SHALL register all decode results into the ID/EX register on rising clk; latency is one cycle from instruction_decode to the _execute outputs.
REQ-020 SHALL, when flush_execute=1, load the ID/EX register with all-zero values (bubble), regardless of stall_decode; flush takes priority.
REQ-021 SHALL, when stall_decode=1 and flush_execute=0, keep every _execute output unchanged.
REQ-022 SHALL still perform the register-file write during a stall or flush.
REQ-023 SHALL leave rs1_decode=inst[19:15] and rs2_decode=inst[24:20] unaffected by stall or flush.

Reset
REQ-024 SHALL, while rst=1, force every _execute output to 0 and every register-file entry to 0, asynchronously.
REQ-025 SHALL make rst assertion mid-operation discard the in-flight ID/EX contents and override stall and flush.
REQ-026 SHALL accept normal operation on the first rising clk after rst deasserts.

Verification
REQ-027 SHALL cover: rst=1 mid-run, then released -> all _execute outputs 0 immediately; reads of x1..x31 return 0.
REQ-028 SHALL cover: write x5=0xDEADBEEF, then R-type add x6,x5,x5 -> one cycle later rd1_execute=rd2_execute=0xDEADBEEF, alu_control=000, rd_execute=6.
REQ-029 SHALL cover: write x7=0x12345678 in the same cycle as decoding addi x8,x7,-1 (0xFFF38413) -> rd1_execute=0x12345678 (WB_BYPASS=1) and imm_ext_execute=0xFFFFFFFF.
REQ-030 SHALL cover: decode beq with B-immediate -8 (inst 0xFE000CE3) -> branch_execute=1, alu_control=001, imm_ext_execute=0xFFFFFFF8.
REQ-031 SHALL cover: stall_decode=1 for 3 cycles while instruction_decode changes -> outputs frozen; flush_execute=1 together with stall_decode=1 -> next cycle all controls 0.
REQ-032 SHALL cover: write to x0 with value 0xFFFFFFFF, then read x0 -> 0; unknown opcode 0x0000007F -> all controls 0.
